// File: rtl/memtest_pkg.sv
// Shared definitions for the RAM tester: state encoding, test pattern and
// read-latency legality check.
package memtest_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5,
      ST_FAIL  = 3'd6
   } state_e;

   // Pattern for address a: the address zero-extended to the data width, XOR seed.
   function automatic logic [31:0] exp_pat(input logic [31:0] a, input logic [31:0] seed,
                                           input int unsigned m);
      logic [31:0] mask;
      mask = (m >= 32) ? '1 : ((32'd1 << m) - 32'd1);
      return (a ^ seed) & mask;
   endfunction

   function automatic bit rd_lat_ok(input int l);
      return (l >= 1) && (l <= 4);
   endfunction

endpackage

// File: rtl/memoria_ram_tester.sv
// Write/read-back tester for the MemoriaRAM block. Optional build macro
// MEMTEST_ERRCNT_EN counts all mismatches instead of stopping at the first.
module memoria_ram_tester
   import memtest_pkg::*;
#(
   parameter int           N      = 4,
   parameter int           M      = 4,
   parameter logic [M-1:0] SEED   = 4'hA,
   parameter int           RD_LAT = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         abort_i,
   output logic [N-1:0] addr_o,
   output logic [M-1:0] dato_write_o,
   output logic         wren_o,
   output logic         rden_o,
   input  logic [M-1:0] dato_read_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         pass_o,
`ifdef MEMTEST_ERRCNT_EN
   output logic [N:0]   err_cnt_o,
`endif
   output logic [N-1:0] fail_addr_o,
   output logic [M-1:0] fail_data_o
);

   if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
      $error("memoria_ram_tester: RD_LAT must be in 1..4");
   end

   localparam logic [N-1:0] CNT_MAX   = '1;
   localparam logic [1:0]   WAIT_LAST = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

   function automatic logic [M-1:0] expected(input logic [N-1:0] a);
      logic [31:0] t;
      t = exp_pat(32'(a), 32'(SEED), M);
      return t[M-1:0];
   endfunction

   state_e       state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [1:0]   wait_q, wait_d;
   logic [N-1:0] fail_addr_q, fail_addr_d;
   logic [M-1:0] fail_data_q, fail_data_d;
   logic [N-1:0] addr_q, addr_d;
   logic [M-1:0] dwr_q, dwr_d;
   logic         wren_q, wren_d, rden_q, rden_d;
   logic         busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic         mismatch;
`ifdef MEMTEST_ERRCNT_EN
   localparam logic [N:0] ERR_SAT = {1'b1, {N{1'b0}}};
   logic [N:0]   err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
`ifdef MEMTEST_ERRCNT_EN
      err_d       = err_q;
`endif
      mismatch    = (dato_read_i != expected(cnt_q));

      case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start_i) begin
               state_d     = ST_WRITE;
               cnt_d       = '0;
               fail_addr_d = '0;
               fail_data_d = '0;
`ifdef MEMTEST_ERRCNT_EN
               err_d       = '0;
`endif
            end
         end
         ST_WRITE: begin
            // Counter wraps to 0 on the last address, ready for the read pass.
            cnt_d = cnt_q + N'(1);
            if (cnt_q == CNT_MAX) state_d = ST_READ;
         end
         ST_READ: begin
            wait_d  = '0;
            state_d = (RD_LAT > 1) ? ST_WAIT : ST_CHECK;
         end
         ST_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = ST_CHECK;
            else                     wait_d  = wait_q + 2'd1;
         end
         ST_CHECK: begin
`ifdef MEMTEST_ERRCNT_EN
            if (mismatch) begin
               if (err_q == '0) begin
                  fail_addr_d = cnt_q;
                  fail_data_d = dato_read_i;
               end
               if (err_q != ERR_SAT) err_d = err_q + (N+1)'(1);
            end
            cnt_d   = cnt_q + N'(1);
            state_d = (cnt_q == CNT_MAX) ? ST_DONE : ST_READ;
`else
            if (mismatch) begin
               fail_addr_d = cnt_q;
               fail_data_d = dato_read_i;
               state_d     = ST_FAIL;
            end else begin
               cnt_d   = cnt_q + N'(1);
               state_d = (cnt_q == CNT_MAX) ? ST_DONE : ST_READ;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort_i) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         wait_d      = '0;
         fail_addr_d = '0;
         fail_data_d = '0;
`ifdef MEMTEST_ERRCNT_EN
         err_d       = '0;
`endif
      end

      // Outputs are decoded from the next state so the registers track the state.
      wren_d = (state_d == ST_WRITE);
      rden_d = (state_d == ST_READ);
      busy_d = (state_d inside {ST_WRITE, ST_READ, ST_WAIT, ST_CHECK});
      addr_d = busy_d ? cnt_d : '0;
      dwr_d  = wren_d ? expected(cnt_d) : '0;
      done_d = (state_d == ST_DONE) || (state_d == ST_FAIL);
`ifdef MEMTEST_ERRCNT_EN
      pass_d = (state_d == ST_DONE) && (err_d == '0);
`else
      pass_d = (state_d == ST_DONE);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wait_q      <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         addr_q      <= '0;
         dwr_q       <= '0;
         wren_q      <= 1'b0;
         rden_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
`ifdef MEMTEST_ERRCNT_EN
         err_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         addr_q      <= addr_d;
         dwr_q       <= dwr_d;
         wren_q      <= wren_d;
         rden_q      <= rden_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
`ifdef MEMTEST_ERRCNT_EN
         err_q       <= err_d;
`endif
      end
   end

   assign addr_o       = addr_q;
   assign dato_write_o = dwr_q;
   assign wren_o       = wren_q;
   assign rden_o       = rden_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign fail_addr_o  = fail_addr_q;
   assign fail_data_o  = fail_data_q;
`ifdef MEMTEST_ERRCNT_EN
   assign err_cnt_o    = err_q;
`endif

endmodule

// File: tb/tb_memoria_ram_tester.sv
// Directed bench: two testers (RD_LAT=1 and RD_LAT=3), each with its own RAM model.
module tb_memoria_ram_tester;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // ---------------- DUT1: RD_LAT = 1 ----------------
   logic       start1 = 1'b0, abort1 = 1'b0;
   logic [3:0] addr1, dwr1, rdat1, faddr1, fdata1;
   logic       wren1, rden1, busy1, done1, pass1;
   logic [3:0] mem1 [16];
   logic [15:0] flip1 = '0;
   logic       rdv1 = 1'b0;
   logic [3:0] rdd1 = '0;
`ifdef MEMTEST_ERRCNT_EN
   logic [4:0] err1, err3;
`endif

   memoria_ram_tester #(.N(4), .M(4), .SEED(4'hA), .RD_LAT(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(abort1),
      .addr_o(addr1), .dato_write_o(dwr1), .wren_o(wren1), .rden_o(rden1),
      .dato_read_i(rdat1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
`ifdef MEMTEST_ERRCNT_EN
      .err_cnt_o(err1),
`endif
      .fail_addr_o(faddr1), .fail_data_o(fdata1));

   // Invalid read cycles return the complement of the stored word, so a
   // mistimed compare always mismatches.
   always @(posedge clk) begin
      if (wren1) mem1[addr1] <= dwr1;
      rdv1 <= rden1;
      rdd1 <= mem1[addr1] ^ {3'b000, flip1[addr1]};
   end
   assign rdat1 = rdv1 ? rdd1 : ~mem1[addr1];

   // ---------------- DUT3: RD_LAT = 3 ----------------
   logic       start3 = 1'b0;
   logic [3:0] addr3, dwr3, rdat3, faddr3, fdata3;
   logic       wren3, rden3, busy3, done3, pass3;
   logic [3:0] mem3 [16];
   logic [15:0] flip3 = '0;
   logic [2:0] rdv3 = '0;
   logic [3:0] rdd3 [3];

   memoria_ram_tester #(.N(4), .M(4), .SEED(4'hA), .RD_LAT(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .abort_i(1'b0),
      .addr_o(addr3), .dato_write_o(dwr3), .wren_o(wren3), .rden_o(rden3),
      .dato_read_i(rdat3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
`ifdef MEMTEST_ERRCNT_EN
      .err_cnt_o(err3),
`endif
      .fail_addr_o(faddr3), .fail_data_o(fdata3));

   always @(posedge clk) begin
      if (wren3) mem3[addr3] <= dwr3;
      rdv3    <= {rdv3[1:0], rden3};
      rdd3[0] <= mem3[addr3] ^ {3'b000, flip3[addr3]};
      rdd3[1] <= rdd3[0];
      rdd3[2] <= rdd3[1];
   end
   assign rdat3 = rdv3[2] ? rdd3[2] : ~mem3[addr3];

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on cycle 1 of a sweep; returns the cycle on which done_o rose.
   task automatic wait_done1(input int limit, output int cyc);
      cyc = 1;
      while (!done1 && cyc < limit) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_done3(input int limit, output int cyc);
      cyc = 1;
      while (!done3 && cyc < limit) begin
         tick();
         cyc++;
      end
   endtask

   int cyc;

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      chk("rst_pass", 32'(pass1), 0);
      chk("rst_wren", 32'(wren1), 0);
      chk("rst_rden", 32'(rden1), 0);
      chk("rst_addr", 32'(addr1), 0);
      chk("rst_dwr", 32'(dwr1), 0);
      chk("rst_faddr", 32'(faddr1), 0);
      chk("rst_fdata", 32'(fdata1), 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy1), 0);

      // Clean sweep, cycle-exact
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int c = 1; c <= 48; c++) begin
         chk("clean_busy", 32'(busy1), 1);
         if (c <= 16) begin
            chk("clean_wren", 32'(wren1), 1);
            chk("clean_waddr", 32'(addr1), 32'(c - 1));
            chk("clean_wdata", 32'(dwr1), 32'(c - 1) ^ 32'hA);
            chk("clean_rden_w", 32'(rden1), 0);
         end else begin
            chk("clean_wren_r", 32'(wren1), 0);
            chk("clean_rden", 32'(rden1), ((c - 17) % 2 == 0) ? 1 : 0);
            chk("clean_raddr", 32'(addr1), 32'((c - 17) / 2));
         end
         tick();
      end
      chk("clean_done", 32'(done1), 1);
      chk("clean_pass", 32'(pass1), 1);
      chk("clean_busy_end", 32'(busy1), 0);

`ifdef MEMTEST_ERRCNT_EN
      // Mismatches at 2 and 9: sweep continues, first one captured
      flip1[2] = 1'b1;
      flip1[9] = 1'b1;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("ec_restart_done", 32'(done1), 0);
      wait_done1(200, cyc);
      chk("ec_cycle", 32'(cyc), 49);
      chk("ec_done", 32'(done1), 1);
      chk("ec_pass", 32'(pass1), 0);
      chk("ec_cnt", 32'(err1), 2);
      chk("ec_faddr", 32'(faddr1), 32'h2);
      chk("ec_fdata", 32'(fdata1), 32'h9);
`else
      // Bit 0 wrong at address 5: expected F, read E
      flip1[5] = 1'b1;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("stuck_restart_done", 32'(done1), 0);
      chk("stuck_restart_pass", 32'(pass1), 0);
      wait_done1(200, cyc);
      chk("stuck_cycle", 32'(cyc), 29);
      chk("stuck_done", 32'(done1), 1);
      chk("stuck_pass", 32'(pass1), 0);
      chk("stuck_busy", 32'(busy1), 0);
      chk("stuck_faddr", 32'(faddr1), 32'h5);
      chk("stuck_fdata", 32'(fdata1), 32'hE);
`endif

      // start_i held high: no mid-sweep restart; restart after DONE
      flip1 = '0;
      start1 = 1'b1;
      tick();
      chk("held_done_clr", 32'(done1), 0);
      chk("held_faddr_clr", 32'(faddr1), 0);
      chk("held_fdata_clr", 32'(fdata1), 0);
      chk("held_busy", 32'(busy1), 1);
      wait_done1(200, cyc);
      chk("held_cycle", 32'(cyc), 49);
      chk("held_pass", 32'(pass1), 1);
      tick();
      chk("held_rest_done", 32'(done1), 0);
      chk("held_rest_pass", 32'(pass1), 0);
      chk("held_rest_wren", 32'(wren1), 1);
      chk("held_rest_addr", 32'(addr1), 0);
      start1 = 1'b0;

      // Reset mid-sweep
      tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_busy", 32'(busy1), 0);
      chk("midrst_wren", 32'(wren1), 0);
      chk("midrst_addr", 32'(addr1), 0);
      rst_n = 1'b1;
      tick();

      // Abort at cnt=7 with start also high: abort wins
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("abort_pre_addr", 32'(addr1), 7);
      chk("abort_pre_wren", 32'(wren1), 1);
      abort1 = 1'b1;
      start1 = 1'b1;
      tick();
      chk("abort_busy", 32'(busy1), 0);
      chk("abort_wren", 32'(wren1), 0);
      chk("abort_rden", 32'(rden1), 0);
      chk("abort_addr", 32'(addr1), 0);
      tick();
      chk("abort_hold_busy", 32'(busy1), 0);
      abort1 = 1'b0;
      tick();
      start1 = 1'b0;
      chk("abort_rs_wren", 32'(wren1), 1);
      chk("abort_rs_addr", 32'(addr1), 0);
      chk("abort_rs_data", 32'(dwr1), 32'hA);
      wait_done1(200, cyc);
      chk("abort_rs_cycle", 32'(cyc), 49);
      chk("abort_rs_pass", 32'(pass1), 1);

      // RD_LAT=3 clean sweep, cycle-exact read strobes
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         chk("lat3_busy", 32'(busy3), 1);
         chk("lat3_excl", 32'(wren3 & rden3), 0);
         if (c > 16) begin
            chk("lat3_rden", 32'(rden3), ((c - 17) % 4 == 0) ? 1 : 0);
            chk("lat3_raddr", 32'(addr3), 32'((c - 17) / 4));
         end
         tick();
      end
      chk("lat3_done", 32'(done3), 1);
      chk("lat3_pass", 32'(pass3), 1);
      chk("lat3_busy_end", 32'(busy3), 0);

`ifndef MEMTEST_ERRCNT_EN
      // RD_LAT=3 with bad data at 5: FAIL after 16 + 6*4 busy cycles
      flip3[5] = 1'b1;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      wait_done3(300, cyc);
      chk("lat3_stuck_cycle", 32'(cyc), 41);
      chk("lat3_stuck_pass", 32'(pass3), 0);
      chk("lat3_stuck_faddr", 32'(faddr3), 32'h5);
      chk("lat3_stuck_fdata", 32'(fdata3), 32'hE);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/memoria_ram_tester.md
Name: memoria_ram_tester

Overview:
- Initiator/controller that drives the write and read ports of the team's parameterizable single-address RAM (MemoriaRAM).
- Replaces switches as the RAM's driver. On start, fills every address with a deterministic pattern, reads each address back, and compares the result.
- Reports busy/done/pass, plus the first failing address and data, for display and LEDs on the FPGA top.

Parameters:
- N, 4: RAM address width; the sweep covers 2^N addresses.
- M, 4: RAM data width.
- SEED, 4'hA: M-bit pattern seed; expected(a) = a[M-1:0] (zero-extended if N<M) XOR SEED.
- RD_LAT, 1: cycles from rden_o high to dato_read_i valid; legal range 1..4.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_ni  in  1  synchronous, active-low reset, sampled on rising clk_i.
- start_i  in  1  level; sampled only in IDLE, DONE or FAIL.
- abort_i  in  1  level; returns the block to IDLE.
- addr_o  out  N  RAM address.
- dato_write_o  out  M  RAM write data.
- wren_o  out  1  RAM write enable.
- rden_o  out  1  RAM read enable.
- dato_read_i  in  M  RAM read data.
- busy_o  out  1  high during WRITE/READ/WAIT/CHECK.
- done_o  out  1  high in DONE or FAIL.
- pass_o  out  1  high only in DONE with zero mismatches.
- fail_addr_o  out  N  address of the first mismatch.
- fail_data_o  out  M  data read at the first mismatch.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low.
- All outputs are registered. Reset values: every output 0; state IDLE; address counter 0; wait counter 0.
- IDLE: wren_o=rden_o=0, addr_o=0. start_i=1 -> WRITE with cnt=0.
- WRITE:
  - Each cycle drives wren_o=1, addr_o=cnt, dato_write_o=expected(cnt).
  - At cnt=2^N-1 -> READ with cnt=0. The counter wraps naturally and needs no extra bit.
  - wren_o is high for exactly 2^N consecutive cycles.
- READ: one cycle with rden_o=1, addr_o=cnt, wren_o=0. Next state is WAIT if RD_LAT>1, otherwise CHECK.
- WAIT: rden_o=0; holds for RD_LAT-1 cycles, then -> CHECK.
- CHECK:
  - Compares dato_read_i with expected(cnt).
  - Match: if cnt=2^N-1 -> DONE, else cnt+1 and -> READ.
  - Mismatch: latch fail_addr_o=cnt and fail_data_o=dato_read_i, then -> FAIL.
- Read phase length: (RD_LAT+1)*2^N cycles.
- DONE: pass_o=1, done_o=1. FAIL: pass_o=0, done_o=1. Both states hold until start_i or abort_i.
- Restart: start_i in DONE/FAIL clears pass_o, done_o, fail_addr_o and fail_data_o, then -> WRITE with cnt=0.
- start_i while busy is ignored.
- abort_i has priority over start_i in every state. Next cycle: IDLE with wren_o=rden_o=0. Sweep results are cleared.
- Reset mid-sweep: outputs go to reset values on the next edge. The RAM contents are not restored.
- wren_o and rden_o are never high in the same cycle.

Optional Feature:
- Macro: MEMTEST_ERRCNT_EN.
- Defined:
  - Adds output err_cnt_o, width N+1, reset 0.
  - A mismatch in CHECK increments err_cnt_o, saturating at 2^N, and the sweep continues.
  - fail_addr_o/fail_data_o capture only the first mismatch.
  - The sweep ends in DONE; pass_o = (err_cnt_o==0).
  - The FAIL state is unused.
- Undefined: the first mismatch ends the sweep in FAIL as described above. No err_cnt_o port.

Decomposition:
- Package memtest_pkg holds:
  - state encoding localparams (IDLE, WRITE, READ, WAIT, CHECK, DONE, FAIL, 3 bits);
  - the expected-pattern function;
  - the RD_LAT legal-range check.
- No sub-module. The FSM, counters and comparator live in one flat module; the wait counter is 2 bits.

Test Plan:
All scenarios use N=4, M=4, SEED=4'hA, RD_LAT=1 with a behavioural RAM model unless stated.
- Clean sweep: pulse start_i -> 16 write cycles with data 4'hA,4'hB,4'h8,... (a^A) -> 32 read/check cycles -> done_o=1, pass_o=1 at cycle 49 after start sampled; busy_o high for 48 cycles.
- Stuck bit: model forces data bit0=0 at address 5 -> FAIL, fail_addr_o=4'h5, fail_data_o=4'hE, pass_o=0, done_o=1.
- Abort: abort_i asserted during WRITE at cnt=7 -> next cycle IDLE, wren_o=0, busy_o=0; a subsequent start_i rewrites from address 0.
- Ignored start and restart: start_i held high throughout a sweep -> no restart mid-sweep; after DONE a new sweep begins and done_o/pass_o clear.
- RD_LAT=3: clean sweep takes 16+64 busy cycles; CHECK samples exactly 3 cycles after each rden_o; check there is no off-by-one.
- MEMTEST_ERRCNT_EN defined, mismatches at addresses 2 and 9 -> DONE, err_cnt_o=2, fail_addr_o=4'h2, pass_o=0.
